uart_receiver: RTL and testbench

- UART receive deserializer: 8N1 frames on the `uart_rx` pin in, bytes out through a 1-entry valid/ready holding register.
- Sits on the mother_board between the `uart_rx` pin and the CPU's memory-mapped I/O read path.
- Bit time is a fixed number of clocks (`WAIT`), matching the transmit side and the board-level bench.

---
 rtl/uart_receiver.sv | 100 ++++++++++
 tb/tb_uart_receiver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART deserializer feeding a one-entry valid/ready holding register
module uart_receiver #(
    parameter int WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] r_data,
    output logic       r_valid,
    input  logic       r_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(WAIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(WAIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WAIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          bad_q, bad_d;
    logic [7:0]    r_data_q, r_data_d;
    logic          r_valid_q, r_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          half_hit, bit_hit, sample, counting;

    assign half_hit = cnt_q == HALF_LAST;
    assign bit_hit  = cnt_q == BIT_LAST;
    assign counting = state_q == START || state_q == DATA || state_q == STOP;
    assign sample   = (state_q == START && half_hit) || ((state_q == DATA || state_q == STOP) && bit_hit);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (half_hit) state_d = rx_s ? IDLE : DATA;
            DATA:    if (bit_hit && idx_q == 3'd7) state_d = STOP;
            STOP:    if (bit_hit) state_d = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Delivery is staged one edge behind the stop sample so the holding register sees a registered strobe
    always_comb begin
        cnt_d       = (counting && !sample) ? cnt_q + 1'b1 : '0;
        idx_d       = state_q != DATA ? 3'd0 : bit_hit ? idx_q + 3'd1 : idx_q;
        shift_d     = (state_q == DATA && bit_hit) ? {rx_s, shift_q[7:1]} : shift_q;
        done_d      = state_q == STOP && bit_hit && rx_s;
        bad_d       = state_q == STOP && bit_hit && !rx_s;
        r_valid_d   = done_q || (r_valid_q && !r_ready);
        r_data_d    = (done_q && (!r_valid_q || r_ready)) ? shift_q : r_data_q;
        overrun_d   = done_q && r_valid_q && !r_ready;
        frame_err_d = bad_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s        <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            rx_s        <= sync1_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
            r_data_q    <= r_data_d;
            r_valid_q   <= r_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign r_data    = r_data_q;
    assign r_valid   = r_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: event-level reference model for three WAIT values, random and directed frames
module tb_uart_receiver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit done [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : blk
        localparam int W = g == 0 ? 8 : g == 1 ? 4 : 13;
        localparam int LAT = 3 + W / 2 + 9 * W;
        localparam int LAT_LIT = g == 0 ? 79 : g == 1 ? 41 : 126;
        localparam logic [7:0] FIRST = g == 0 ? 8'h0F : 8'h00;
        logic       reset = 1'b1, uart_rx = 1'b1, r_ready = 1'b0;
        logic       r_valid, frame_err, overrun;
        logic [7:0] r_data;
        int         cyc = 0, pin_c = -1000, n_fe = 0, n_ov = 0;
        bit         rnd = 0;
        logic [7:0] dv [int];
        bit         fe [int];

        uart_receiver #(.WAIT(W)) dut (
            .clk(clk), .reset(reset), .uart_rx(uart_rx), .r_data(r_data), .r_valid(r_valid),
            .r_ready(r_ready), .frame_err(frame_err), .overrun(overrun)
        );

        // Expected outcome of each frame lands at a fixed edge count after its first low edge
        initial begin : mon
            bit v = 0;
            logic [7:0] d = 8'h00;
            bit ov, ef, rs, rd;
            forever begin
                @(posedge clk);
                cyc++;
                rs = reset;
                rd = r_ready;
                ov = 0;
                ef = 0;
                if (rs) v = 0;
                else begin
                    ef = fe.exists(cyc);
                    if (dv.exists(cyc)) begin
                        if (!v || rd) begin
                            v = 1;
                            d = dv[cyc];
                        end else ov = 1;
                    end else if (v && rd) v = 0;
                end
                #1;
                chk("r_valid", r_valid, v);
                if (v) chk("r_data", r_data, d);
                if (rs) chk("r_data_reset", r_data, 0);
                chk("frame_err", frame_err, ef);
                chk("overrun", overrun, ov);
                n_fe += int'(frame_err);
                n_ov += int'(overrun);
                if (cyc == pin_c + LAT_LIT - 1) chk("lat_before", r_valid, 0);
                if (cyc == pin_c + LAT_LIT) chk("lat_at", {r_valid, r_data}, {1'b1, FIRST});
            end
        end

        initial begin : rdy
            forever begin
                @(negedge clk);
                #1;
                if (rnd) r_ready = $urandom_range(0, 3) == 0;
            end
        end

        task automatic idle(input int n);
            repeat (n) @(negedge clk);
        endtask

        task automatic frame(input logic [7:0] b, input bit stop, input int abort);
            bit [9:0] bits;
            int c;
            bits = {stop, b, 1'b0};
            c = cyc + 1;
            if (abort < 0) begin
                if (stop) dv[c + LAT] = b;
                else fe[c + LAT] = 1;
            end
            for (int i = 0; i < 10; i++) begin
                for (int k = 0; k < W; k++) begin
                    if (abort >= 0 && i == abort + 1 && k == W / 2) begin
                        reset = 1'b1;
                        uart_rx = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        return;
                    end
                    uart_rx = bits[i];
                    @(negedge clk);
                end
            end
        endtask

        task automatic glitch(input int l);
            uart_rx = 1'b0;
            idle(l);
            uart_rx = 1'b1;
            idle(W + 4);
        endtask

        task automatic consume();
            r_ready = 1'b1;
            @(negedge clk);
            r_ready = 1'b0;
            idle(2);
        endtask

        initial begin : drv
            int k;
            idle(3);
            reset = 1'b0;
            idle(3);
            pin_c = cyc + 1;
            frame(FIRST, 1, -1);
            idle(4);
            consume();
            frame(8'hFF, 1, -1);
            idle(4);
            consume();
            glitch(g == 0 ? 3 : W / 2);
            frame(8'hA5, 1, -1);
            idle(4);
            consume();
            frame(8'h3C, 0, -1);
            idle(40);
            uart_rx = 1'b1;
            idle(4);
            chk("one_frame_err", n_fe, 1);
            frame(8'h55, 1, -1);
            idle(4);
            consume();
            frame(8'h11, 1, -1);
            frame(8'h22, 1, -1);
            idle(4);
            chk("held_byte", {r_valid, r_data}, {1'b1, 8'h11});
            chk("one_overrun", n_ov, 1);
            consume();
            r_ready = 1'b1;
            frame(8'h33, 1, -1);
            frame(8'h44, 1, -1);
            idle(4);
            r_ready = 1'b0;
            chk("no_overrun", n_ov, 1);
            frame(8'h66, 1, -1);
            idle(4);
            frame(8'h99, 1, 4);
            idle(W * 12);
            chk("aborted", r_valid, 0);
            frame(8'h7E, 1, -1);
            idle(4);
            chk("after_abort", {r_valid, r_data}, {1'b1, 8'h7E});
            consume();
            rnd = 1;
            repeat (30) begin
                k = $urandom_range(0, 9);
                if (k == 0) glitch($urandom_range(1, W / 2));
                else if (k == 1) begin
                    frame(8'($urandom_range(0, 255)), 0, -1);
                    idle($urandom_range(0, 20));
                    uart_rx = 1'b1;
                    idle($urandom_range(2, 5));
                end else begin
                    frame(8'($urandom_range(0, 255)), 1, -1);
                    idle($urandom_range(0, 3));
                end
            end
            rnd = 0;
            r_ready = 1'b0;
            idle(LAT + 10);
            done[g] = 1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(done[0] && done[1] && done[2]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk("all_done", {done[0], done[1], done[2]}, 3'b111);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
